// File: rtl/cv32e40p_hwloop_ctrl_seq.sv
// Hardware-loop controller: sequences setup writes into the hwloop regs and raises jump/decrement at armed loop ends.
// Define HWLP_ADDR_CHECK_EN to reject malformed setups (end<=start or misaligned end) and pulse setup_err_o.
module cv32e40p_hwloop_ctrl_seq #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         setup_valid_i,
  output logic                         setup_ready_o,
  input  logic [N_REG_BITS-1:0]        setup_regid_i,
  input  logic [31:0]                  setup_start_i,
  input  logic [31:0]                  setup_end_i,
  input  logic [31:0]                  setup_cnt_i,
  output logic [31:0]                  hwlp_start_data_o,
  output logic [31:0]                  hwlp_end_data_o,
  output logic [31:0]                  hwlp_cnt_data_o,
  output logic [2:0]                   hwlp_we_o,
  output logic [N_REG_BITS-1:0]        hwlp_regid_o,
  output logic                         hwlp_valid_o,
  output logic [N_REGS-1:0]            hwlp_dec_cnt_o,
  input  logic [N_REGS-1:0][31:0]      hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]      hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]      hwlp_counter_i,
  input  logic                         pc_valid_i,
  input  logic [31:0]                  pc_i,
  output logic                         jump_o,
  output logic [31:0]                  jump_target_o,
  output logic [N_REGS-1:0]            armed_o,
`ifdef HWLP_ADDR_CHECK_EN
  output logic                         setup_err_o,
`endif
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, WR_START, WR_END, WR_CNT} state_e;

  state_e                 state_q;
  logic [N_REG_BITS-1:0]  regid_q;
  logic [31:0]            start_q, end_q, cnt_q;
  logic [N_REGS-1:0]      armed_q, armed_d;
  logic [N_REGS-1:0]      hit;
  logic [N_REG_BITS-1:0]  win;
  logic                   any_hit, retire, accept, bad_addr;

  assign setup_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign accept        = setup_valid_i && setup_ready_o;
  assign armed_o       = armed_q;

`ifdef HWLP_ADDR_CHECK_EN
  logic err_q;
  assign bad_addr    = (setup_end_i <= setup_start_i) || (setup_end_i[1:0] != 2'b00);
  assign setup_err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && bad_addr;
  end
`else
  assign bad_addr = 1'b0;
`endif

  // Loop-end match; lowest index wins because loop 0 is the innermost.
  always_comb begin
    hit = '0;
    win = '0;
    for (int i = 0; i < N_REGS; i++) begin
      hit[i] = pc_valid_i && armed_q[i] && (pc_i == hwlp_end_addr_i[i]) &&
               (hwlp_counter_i[i] != 32'd0);
    end
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (hit[i]) win = N_REG_BITS'(i);
    end
  end

  assign any_hit        = |hit;
  assign retire         = any_hit && (hwlp_counter_i[win] == 32'd1);
  assign hwlp_valid_o   = any_hit;
  assign hwlp_dec_cnt_o = any_hit ? (N_REGS'(1) << win) : '0;
  assign jump_o         = any_hit && (hwlp_counter_i[win] > 32'd1);
  assign jump_target_o  = jump_o ? hwlp_start_addr_i[win] : 32'd0;

  // A fresh accept overrides any retire or arm on the same loop.
  always_comb begin
    armed_d = armed_q;
    if (retire) armed_d[win] = 1'b0;
    if (state_q == WR_CNT && cnt_q != 32'd0) armed_d[regid_q] = 1'b1;
    if (accept) armed_d[setup_regid_i] = 1'b0;
  end

  always_comb begin
    hwlp_we_o = 3'b000;
    unique case (state_q)
      WR_START: hwlp_we_o = 3'b001;
      WR_END:   hwlp_we_o = 3'b010;
      WR_CNT:   hwlp_we_o = 3'b100;
      default:  hwlp_we_o = 3'b000;
    endcase
  end

  assign hwlp_start_data_o = hwlp_we_o[0] ? start_q : 32'd0;
  assign hwlp_end_data_o   = hwlp_we_o[1] ? end_q   : 32'd0;
  assign hwlp_cnt_data_o   = hwlp_we_o[2] ? cnt_q   : 32'd0;
  assign hwlp_regid_o      = busy_o ? regid_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      regid_q <= '0;
      start_q <= 32'd0;
      end_q   <= 32'd0;
      cnt_q   <= 32'd0;
      armed_q <= '0;
    end else begin
      armed_q <= armed_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            regid_q <= setup_regid_i;
            start_q <= setup_start_i;
            end_q   <= setup_end_i;
            cnt_q   <= setup_cnt_i;
            if (!bad_addr) state_q <= WR_START;
          end
        end
        WR_START: state_q <= WR_END;
        WR_END:   state_q <= WR_CNT;
        WR_CNT:   state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl_seq.sv
// Scoreboard bench for cv32e40p_hwloop_ctrl_seq: setup sequencing, loop iteration, nesting priority and reset.
module tb_cv32e40p_hwloop_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic setupValid;
  logic setupRegid;
  logic [31:0] setupStart, setupEnd, setupCnt;
  logic [31:0] startData, endData, cntData;
  logic [2:0] we;
  logic regidOut;
  logic hwlpValid;
  logic [1:0] decCnt;
  logic [1:0][31:0] startAddr, endAddr, counter;
  logic pcValid;
  logic [31:0] pc;
  logic jump;
  logic [31:0] jumpTarget;
  logic [1:0] armed;
  logic busy, ready;
`ifdef HWLP_ADDR_CHECK_EN
  logic setupErr;
`endif

  int checks = 0;
  int failures = 0;
  logic [139:0] sb[$];

  typedef struct {
    logic v; logic id; logic [31:0] s, e, c;
    logic pv; logic [31:0] pc, c0, c1;
    logic [139:0] ex;
  } row_t;

  always #5 clk = ~clk;

  cv32e40p_hwloop_ctrl_seq #(.N_REGS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .setup_valid_i(setupValid), .setup_ready_o(ready), .setup_regid_i(setupRegid),
    .setup_start_i(setupStart), .setup_end_i(setupEnd), .setup_cnt_i(setupCnt),
    .hwlp_start_data_o(startData), .hwlp_end_data_o(endData), .hwlp_cnt_data_o(cntData),
    .hwlp_we_o(we), .hwlp_regid_o(regidOut), .hwlp_valid_o(hwlpValid), .hwlp_dec_cnt_o(decCnt),
    .hwlp_start_addr_i(startAddr), .hwlp_end_addr_i(endAddr), .hwlp_counter_i(counter),
    .pc_valid_i(pcValid), .pc_i(pc), .jump_o(jump), .jump_target_o(jumpTarget),
    .armed_o(armed),
`ifdef HWLP_ADDR_CHECK_EN
    .setup_err_o(setupErr),
`endif
    .busy_o(busy)
  );

  wire [139:0] obsVec = {ready, busy, we, regidOut, startData, endData, cntData,
                         hwlpValid, decCnt, jump, jumpTarget, armed};

  function automatic logic [139:0] expv(logic rdy, logic bsy, logic [2:0] w, logic id,
                                        logic [31:0] s, logic [31:0] e, logic [31:0] c,
                                        logic vld, logic [1:0] dec, logic jmp,
                                        logic [31:0] tgt, logic [1:0] arm);
    return {rdy, bsy, w, id, s, e, c, vld, dec, jmp, tgt, arm};
  endfunction

  function automatic logic [139:0] idleEx(logic [1:0] arm);
    return expv(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 32'd0, arm);
  endfunction

  function automatic row_t mkRow(logic v, logic id, logic [31:0] s, logic [31:0] e,
                                 logic [31:0] c, logic pv, logic [31:0] p,
                                 logic [31:0] c0, logic [31:0] c1, logic [139:0] ex);
    row_t r;
    r.v = v; r.id = id; r.s = s; r.e = e; r.c = c;
    r.pv = pv; r.pc = p; r.c0 = c0; r.c1 = c1; r.ex = ex;
    return r;
  endfunction

  task automatic applyRow(input row_t r);
    setupValid = r.v; setupRegid = r.id;
    setupStart = r.s; setupEnd = r.e; setupCnt = r.c;
    pcValid = r.pv; pc = r.pc;
    counter[0] = r.c0; counter[1] = r.c1;
  endtask

  task automatic test_reset();
    logic [139:0] expd;
    rst_n = 1'b0;
    applyRow(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    startAddr = '0; endAddr = '0;
    sb.push_back(idleEx(2'b00));
    @(negedge clk);
    expd = sb.pop_front();
    checks++;
    if (obsVec !== expd) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h want %h", obsVec, expd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(idleEx(2'b00));
    @(negedge clk);
    expd = sb.pop_front();
    checks++;
    if (obsVec !== expd) begin
      failures++;
      $display("[TB] FAIL reset_released: got %h want %h", obsVec, expd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_setup();
    row_t rows[$];
    logic [139:0] expd;
    startAddr[0] = 32'h100; endAddr[0] = 32'h120;
    startAddr[1] = 32'h180; endAddr[1] = 32'h140;
    rows.push_back(mkRow(1, 0, 32'h100, 32'h120, 3, 0, 0, 3, 0, idleEx(2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 3, 0,
                   expv(0, 1, 3'b001, 0, 32'h100, 0, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 3, 0,
                   expv(0, 1, 3'b010, 0, 0, 32'h120, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 3, 0,
                   expv(0, 1, 3'b100, 0, 0, 0, 32'd3, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 3, 0, idleEx(2'b01)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      @(negedge clk);
      expd = sb.pop_front();
      checks++;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL setup row%0d: got %h want %h", i, obsVec, expd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_iteration();
    row_t rows[$];
    logic [139:0] expd;
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h120, 3, 0,
                   expv(1, 0, 3'b000, 0, 0, 0, 0, 1, 2'b01, 1, 32'h100, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h11C, 2, 0, idleEx(2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h120, 2, 0,
                   expv(1, 0, 3'b000, 0, 0, 0, 0, 1, 2'b01, 1, 32'h100, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 32'h120, 1, 0, idleEx(2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h120, 1, 0,
                   expv(1, 0, 3'b000, 0, 0, 0, 0, 1, 2'b01, 0, 0, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h120, 1, 0, idleEx(2'b00)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      @(negedge clk);
      expd = sb.pop_front();
      checks++;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL iteration row%0d: got %h want %h", i, obsVec, expd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_count();
    row_t rows[$];
    logic [139:0] expd;
    startAddr[1] = 32'h300; endAddr[1] = 32'h320;
    rows.push_back(mkRow(1, 1, 32'h300, 32'h320, 0, 0, 0, 0, 5, idleEx(2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 5,
                   expv(0, 1, 3'b001, 1, 32'h300, 0, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 5,
                   expv(0, 1, 3'b010, 1, 0, 32'h320, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 5,
                   expv(0, 1, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h320, 0, 5, idleEx(2'b00)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      @(negedge clk);
      expd = sb.pop_front();
      checks++;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL zero_count row%0d: got %h want %h", i, obsVec, expd);
      end
      @(posedge clk); #1;
    end
  endtask

  // Two nested loops sharing an end address, then a re-setup of loop 0 colliding with its own hit.
  task automatic test_back_to_back();
    row_t rows[$];
    logic [139:0] expd;
    startAddr[0] = 32'h100; endAddr[0] = 32'h140;
    startAddr[1] = 32'h180; endAddr[1] = 32'h140;
    rows.push_back(mkRow(1, 0, 32'h100, 32'h140, 2, 0, 0, 2, 4, idleEx(2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b001, 0, 32'h100, 0, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b010, 0, 0, 32'h140, 0, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b100, 0, 0, 0, 32'd2, 0, 2'b00, 0, 0, 2'b00)));
    rows.push_back(mkRow(1, 1, 32'h180, 32'h140, 4, 0, 0, 2, 4, idleEx(2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b001, 1, 32'h180, 0, 0, 0, 2'b00, 0, 0, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b010, 1, 0, 32'h140, 0, 0, 2'b00, 0, 0, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b100, 1, 0, 0, 32'd4, 0, 2'b00, 0, 0, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h140, 2, 4,
                   expv(1, 0, 3'b000, 0, 0, 0, 0, 1, 2'b01, 1, 32'h100, 2'b11)));
    rows.push_back(mkRow(1, 0, 32'h100, 32'h140, 2, 1, 32'h140, 2, 4,
                   expv(1, 0, 3'b000, 0, 0, 0, 0, 1, 2'b01, 1, 32'h100, 2'b11)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 1, 32'h140, 2, 4,
                   expv(0, 1, 3'b001, 0, 32'h100, 0, 0, 1, 2'b10, 1, 32'h180, 2'b10)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b010, 0, 0, 32'h140, 0, 0, 2'b00, 0, 0, 2'b10)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b100, 0, 0, 0, 32'd2, 0, 2'b00, 0, 0, 2'b10)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4, idleEx(2'b11)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      @(negedge clk);
      expd = sb.pop_front();
      checks++;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL back_to_back row%0d: got %h want %h", i, obsVec, expd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    logic [139:0] expd;
    rows.push_back(mkRow(1, 1, 32'h180, 32'h140, 4, 0, 0, 2, 4, idleEx(2'b11)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b001, 1, 32'h180, 0, 0, 0, 2'b00, 0, 0, 2'b01)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 2, 4,
                   expv(0, 1, 3'b010, 1, 0, 32'h140, 0, 0, 2'b00, 0, 0, 2'b01)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      @(negedge clk);
      expd = sb.pop_front();
      checks++;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL async_reset row%0d: got %h want %h", i, obsVec, expd);
      end
      if (i < rows.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    // Still inside the WR_END cycle: reset must take effect without a clock edge.
    #1 rst_n = 1'b0;
    sb.push_back(idleEx(2'b00));
    #1;
    expd = sb.pop_front();
    checks++;
    if (obsVec !== expd) begin
      failures++;
      $display("[TB] FAIL async_reset_immediate: got %h want %h", obsVec, expd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(idleEx(2'b00));
    @(negedge clk);
    expd = sb.pop_front();
    checks++;
    if (obsVec !== expd) begin
      failures++;
      $display("[TB] FAIL async_reset_after: got %h want %h", obsVec, expd);
    end
    @(posedge clk); #1;
  endtask

`ifdef HWLP_ADDR_CHECK_EN
  task automatic test_addr_check();
    row_t rows[$];
    logic [139:0] expd;
    logic errExp[$];
    logic errWant;
    rows.push_back(mkRow(1, 0, 32'h200, 32'h1F0, 3, 0, 0, 0, 0, idleEx(2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 0, idleEx(2'b00)));
    rows.push_back(mkRow(0, 0, 0, 0, 0, 0, 0, 0, 0, idleEx(2'b00)));
    foreach (rows[i]) begin
      applyRow(rows[i]);
      sb.push_back(rows[i].ex);
      errExp.push_back(i == 1);
      @(negedge clk);
      expd = sb.pop_front();
      errWant = errExp.pop_front();
      checks += 2;
      if (obsVec !== expd) begin
        failures++;
        $display("[TB] FAIL addr_check row%0d: got %h want %h", i, obsVec, expd);
      end
      if (setupErr !== errWant) begin
        failures++;
        $display("[TB] FAIL addr_check_err row%0d: got %b want %b", i, setupErr, errWant);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_setup();
    test_iteration();
    test_zero_count();
    test_back_to_back();
    test_async_reset();
`ifdef HWLP_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_hwloop_ctrl_seq.md
Name: cv32e40p_hwloop_ctrl_seq

Overview:
- Controller and sequencer for the cv32e40p hardware-loop register file.
- Accepts loop-setup commands over a valid/ready handshake and sequences the start, end and count writes into the hwloop registers, one field per cycle.
- Tracks which loops are armed, compares the fetch PC against the armed loop end addresses, and issues jump and counter-decrement controls.
- Sits between the decoder/CSR path and the hwloop regs, alongside the prefetch stage.

Parameters:
N_REGS, 2, number of hardware loops (register sets)
N_REG_BITS, $clog2(N_REGS), width of the loop index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
setup_valid_i  in  1  setup command valid
setup_ready_o  out  1  controller can accept a setup
setup_regid_i  in  N_REG_BITS  target loop
setup_start_i  in  32  loop start address
setup_end_i  in  32  loop end address (last instruction)
setup_cnt_i  in  32  iteration count
hwlp_start_data_o  out  32  start write data to regs
hwlp_end_data_o  out  32  end write data to regs
hwlp_cnt_data_o  out  32  count write data to regs
hwlp_we_o  out  3  write enables: [0] start, [1] end, [2] count
hwlp_regid_o  out  N_REG_BITS  register set being written
hwlp_valid_o  out  1  qualifies decrement (drives regs valid_i)
hwlp_dec_cnt_o  out  N_REGS  per-loop decrement pulse
hwlp_start_addr_i  in  N_REGS x 32  current start addresses from regs
hwlp_end_addr_i  in  N_REGS x 32  current end addresses from regs
hwlp_counter_i  in  N_REGS x 32  current counters from regs
pc_valid_i  in  1  pc_i is a valid fetch
pc_i  in  32  fetch PC
jump_o  out  1  redirect fetch to loop start
jump_target_o  out  32  redirect address
armed_o  out  N_REGS  armed loop bitmap
busy_o  out  1  setup sequence in progress

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: FSM=IDLE, armed=0, latched setup fields=0, all outputs 0 except setup_ready_o=1.
- FSM IDLE:
  - setup_ready_o=1.
  - On setup_valid_i&&setup_ready_o: latch regid/start/end/cnt, clear armed[regid], go to WR_START.
- WR_START: hwlp_we_o=3'b001, hwlp_start_data_o=latched start, hwlp_regid_o=latched id; next state WR_END.
- WR_END: hwlp_we_o=3'b010; next state WR_CNT.
- WR_CNT:
  - hwlp_we_o=3'b100.
  - Next cycle armed[id] is set iff cnt!=0; return to IDLE.
  - A setup costs 3 cycles; accept-to-armed latency is 4 cycles.
- Non-IDLE states: setup_ready_o=0, busy_o=1. Data outputs are 0 whenever the corresponding we bit is 0.
- Loop-end detection (combinational, every cycle including during setup):
  - hit[i] = pc_valid_i && armed[i] && pc_i==hwlp_end_addr_i[i] && hwlp_counter_i[i]!=0.
  - Lowest index wins (loop 0 is the innermost). Only the winner w acts.
  - hwlp_dec_cnt_o[w]=1, hwlp_valid_o=1.
  - counter[w]>1: jump_o=1, jump_target_o=hwlp_start_addr_i[w].
  - counter[w]==1: jump_o=0, jump_target_o=0; armed[w] clears on the next edge (loop retired).
  - No hit: all of jump_o, jump_target_o, hwlp_dec_cnt_o and hwlp_valid_o are 0.
- Simultaneous events:
  - Setup accept on regid k in the same cycle as a hit on k: the accept wins, armed[k] clears, and the hit's dec/jump outputs are still driven that cycle.
  - A loop whose setup is in flight is never armed, so it cannot hit.
- Counter width: 32-bit unsigned compares only; no wrap handling required (regs saturate nothing).
- Reset mid-sequence: FSM returns to IDLE and armed clears; partial register writes are not undone.

Optional Feature:
- Macro: HWLP_ADDR_CHECK_EN.
- Defined:
  - A setup with setup_end_i<=setup_start_i or setup_end_i[1:0]!=0 is still accepted (one-cycle handshake).
  - No register writes occur, armed[regid] is cleared, and extra output setup_err_o pulses high for 1 cycle after acceptance.
  - FSM stays in IDLE.
- Undefined: no check and no setup_err_o port; every setup runs the 3-cycle write sequence.

Test Plan:
- Reset: assert rst_n=0 mid-WR_END → all outputs 0, setup_ready_o=1, armed_o=0 immediately (asynchronous).
- Setup: id0, start=0x100, end=0x120, cnt=3 → we sequence 001,010,100 on consecutive cycles with matching data; armed_o=2'b01 on 4th cycle; ready low for 3 cycles.
- Iteration: loop id0 armed, cnt=3, pc=0x120 presented 3 times → jump_o=1 with target 0x100 twice, dec_cnt_o=01 each time; third hit gives jump_o=0; armed_o=00 after.
- Nesting: id0 end=0x140, id1 end=0x140, both armed, cnt≥2, pc=0x140 → only dec_cnt_o=01, target = start[0].
- Zero count: setup cnt=0 → writes occur, armed stays 0, pc==end produces no jump.
- Option: with HWLP_ADDR_CHECK_EN, setup start=0x200 end=0x1F0 → hwlp_we_o stays 0, setup_err_o=1 for 1 cycle, ready remains 1.
